// File: rtl/ycbcr_2_rgb.sv
// Four-stage pipelined YCbCr to RGB converter: offset subtract, 3x3 signed matrix, round/shift, saturate.
// Define YCBCR2RGB_ROUND_EN to round half up before the shift; otherwise results truncate toward -inf.
module ycbcr_2_rgb #(
    parameter int COE_WIDTH          = 13,
    parameter int COE_FRACTION_WIDTH = 10,
    parameter int PIXEL_WIDTH        = 8,
    parameter int BYPASS_WIDTH       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [COE_WIDTH-1:0]   CI_A00,
    input  logic signed [COE_WIDTH-1:0]   CI_A01,
    input  logic signed [COE_WIDTH-1:0]   CI_A02,
    input  logic signed [COE_WIDTH-1:0]   CI_A10,
    input  logic signed [COE_WIDTH-1:0]   CI_A11,
    input  logic signed [COE_WIDTH-1:0]   CI_A12,
    input  logic signed [COE_WIDTH-1:0]   CI_A20,
    input  logic signed [COE_WIDTH-1:0]   CI_A21,
    input  logic signed [COE_WIDTH-1:0]   CI_A22,
    input  logic        [PIXEL_WIDTH-1:0] CI_C0,
    input  logic        [PIXEL_WIDTH-1:0] CI_C1,
    input  logic        [PIXEL_WIDTH-1:0] CI_C2,
    input  logic        [PIXEL_WIDTH-1:0] y_i,
    input  logic        [PIXEL_WIDTH-1:0] cb_i,
    input  logic        [PIXEL_WIDTH-1:0] cr_i,
    input  logic                          de_i,
    input  logic                          hs_i,
    input  logic                          vs_i,
    input  logic       [BYPASS_WIDTH-1:0] bypass_di,
    output logic        [PIXEL_WIDTH-1:0] r_o,
    output logic        [PIXEL_WIDTH-1:0] g_o,
    output logic        [PIXEL_WIDTH-1:0] b_o,
    output logic                          de_o,
    output logic                          hs_o,
    output logic                          vs_o,
    output logic       [BYPASS_WIDTH-1:0] bypass_do
);

    localparam int DW  = PIXEL_WIDTH + 1;
    localparam int PRW = COE_WIDTH + DW;
    localparam int SW  = PRW + 2;
    localparam int RW  = SW + 1;
    localparam int SBW = 3 + BYPASS_WIDTH;

`ifdef YCBCR2RGB_ROUND_EN
    localparam logic signed [RW-1:0] ROUND = RW'(2 ** (COE_FRACTION_WIDTH - 1));
`else
    localparam logic signed [RW-1:0] ROUND = '0;
`endif

    logic signed [COE_WIDTH-1:0]   w_a   [9];
    logic signed [DW-1:0]          w_d   [3];
    logic signed [RW-1:0]          w_rnd [3];
    logic signed [RW-1:0]          w_shf [3];
    logic        [PIXEL_WIDTH-1:0] w_pix [3];

    logic signed [DW-1:0]          r_d   [3];
    logic signed [PRW-1:0]         r_p   [9];
    logic signed [SW-1:0]          r_s   [3];
    logic        [PIXEL_WIDTH-1:0] r_rgb [3];
    logic        [SBW-1:0]         r_sb  [4];

    assign w_a[0] = CI_A00;
    assign w_a[1] = CI_A01;
    assign w_a[2] = CI_A02;
    assign w_a[3] = CI_A10;
    assign w_a[4] = CI_A11;
    assign w_a[5] = CI_A12;
    assign w_a[6] = CI_A20;
    assign w_a[7] = CI_A21;
    assign w_a[8] = CI_A22;

    assign w_d[0] = $signed({1'b0, y_i})  - $signed({1'b0, CI_C0});
    assign w_d[1] = $signed({1'b0, cb_i}) - $signed({1'b0, CI_C1});
    assign w_d[2] = $signed({1'b0, cr_i}) - $signed({1'b0, CI_C2});

    // Row sums never exceed SW bits, so one extra bit keeps the rounding add exact.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_rnd[r] = RW'(r_s[r]) + ROUND;
            w_shf[r] = w_rnd[r] >>> COE_FRACTION_WIDTH;
            w_pix[r] = '0;
            if (w_shf[r][RW-1]) begin
                w_pix[r] = '0;
            end else if (|w_shf[r][RW-2:PIXEL_WIDTH]) begin
                w_pix[r] = '1;
            end else begin
                w_pix[r] = w_shf[r][PIXEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_d[i]   <= '0;
                r_s[i]   <= '0;
                r_rgb[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                r_p[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_d[i]   <= w_d[i];
                r_s[i]   <= SW'(r_p[3*i]) + SW'(r_p[3*i+1]) + SW'(r_p[3*i+2]);
                r_rgb[i] <= w_pix[i];
            end
            for (int i = 0; i < 9; i++) begin
                r_p[i] <= PRW'(w_a[i]) * PRW'(r_d[i%3]);
            end
            r_sb[0] <= {de_i, hs_i, vs_i, bypass_di};
            for (int i = 1; i < 4; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    assign r_o = r_rgb[0];
    assign g_o = r_rgb[1];
    assign b_o = r_rgb[2];
    assign {de_o, hs_o, vs_o, bypass_do} = r_sb[3];

endmodule
